// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder.
// Holds the record-kind and FSM-state encodings, the kind width, the record
// width helper and the retire-event classifier.
// Record layout, MSB to LSB: inum, kind, pc, inst, wreg, wdata, addr, mdata.
package trace_pkg;

  localparam int unsigned KIND_W = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  // Width of one packed trace record.
  function automatic int unsigned rec_width(input int unsigned cnt_w,
                                            input int unsigned data_w,
                                            input int unsigned reg_w);
    return cnt_w + KIND_W + 5 * data_w + reg_w;
  endfunction

  // Priority classification of one retire event; halt wins over everything.
  function automatic kind_e classify(input logic halt,
                                     input logic regwrite,
                                     input logic memread,
                                     input logic memwrite);
    kind_e k;
    k = KIND_NOP;
    if (halt)                      k = KIND_HALT;
    else if (regwrite && memwrite) k = KIND_STU;
    else if (regwrite && memread)  k = KIND_LD;
    else if (regwrite)             k = KIND_REG;
    else if (memwrite)             k = KIND_ST;
    return k;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-event and trace-read bus of the commit-trace recorder.
// master: pipeline/debug side (drives enable, commit_*, rd_ready).
// slave : recorder side (drives rd_valid, rd_record).
interface commit_trace_buffer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned REC_W  = 118
);

  logic              enable;
  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_inst;
  logic              commit_regwrite;
  logic [REG_W-1:0]  commit_wreg;
  logic [DATA_W-1:0] commit_wdata;
  logic              commit_memread;
  logic              commit_memwrite;
  logic [DATA_W-1:0] commit_memaddr;
  logic [DATA_W-1:0] commit_memdata;
  logic              commit_halt;
  logic              rd_ready;
  logic              rd_valid;
  logic [REC_W-1:0]  rd_record;

  modport master (
    output enable, commit_valid, commit_pc, commit_inst, commit_regwrite,
           commit_wreg, commit_wdata, commit_memread, commit_memwrite,
           commit_memaddr, commit_memdata, commit_halt, rd_ready,
    input  rd_valid, rd_record
  );

  modport slave (
    input  enable, commit_valid, commit_pc, commit_inst, commit_regwrite,
           commit_wreg, commit_wdata, commit_memread, commit_memwrite,
           commit_memaddr, commit_memdata, commit_halt, rd_ready,
    output rd_valid, rd_record
  );

endinterface

// File: rtl/trace_fifo.sv
// Show-ahead circular buffer for trace records.
// Ports: clk, rst (sync, active high); push_i/data_i write request;
// pop_i read request (ignored while empty); valid_o/head_o head record;
// occupancy_o entries held; drop_o/overwrite_o flag a push that met a full
// buffer without a simultaneous pop (drop when WRAP_MODE=0, overwrite of the
// oldest entry when WRAP_MODE=1).
module trace_fifo #(
  parameter int unsigned W         = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic                     valid_o,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     drop_o,
  output logic                     overwrite_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_c, do_pop_c, blocked_c, write_c;

  assign full_c      = (occ_q == OCC_W'(DEPTH));
  assign do_pop_c    = pop_i & (occ_q != '0);
  // A simultaneous pop frees a slot, so only a pop-less push into a full buffer is blocked.
  assign blocked_c   = push_i & full_c & ~do_pop_c;
  assign drop_o      = blocked_c & (WRAP_MODE == 0);
  assign overwrite_o = blocked_c & (WRAP_MODE != 0);
  assign write_c     = push_i & ~drop_o;

  // Next pointers/occupancy; an overwrite advances both pointers and keeps occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (write_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c | overwrite_o) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (write_c & ~do_pop_c & ~overwrite_o) occ_d = occ_q + OCC_W'(1);
    else if (~write_c & do_pop_c)           occ_d = occ_q - OCC_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Record storage; contents survive reset, pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (write_c) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o     = (occ_q != '0);
  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder beside the writeback stage.
// Ports: clk, rst (sync, active high); bus (slave modport) carries enable,
// the retire event commit_*, and the rd_valid/rd_ready/rd_record drain port;
// occupancy, inst_count, cycle_count, dropped_count, overflow, halted status.
// Each captured event is classified, numbered with the pre-increment
// inst_count and pushed into trace_fifo; it is visible one cycle later.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_W     = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       inst_count,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       dropped_count,
  output logic                   overflow,
  output logic                   halted
);

  localparam int unsigned REC_W = rec_width(CNT_W, DATA_W, REG_W);

  state_e           state_q;
  logic [CNT_W-1:0] inst_count_q, cycle_count_q, dropped_count_q;
  logic             overflow_q, halted_q;
  logic             event_c, drop_c, overwrite_c;
  kind_e            kind_c;
  logic [REC_W-1:0] record_c;

  // Capture only real retires while running.
  assign event_c = (state_q == ST_RUN) & bus.enable & bus.commit_valid;
  assign kind_c  = classify(bus.commit_halt, bus.commit_regwrite,
                            bus.commit_memread, bus.commit_memwrite);
  assign record_c = {inst_count_q, kind_c, bus.commit_pc, bus.commit_inst,
                     bus.commit_wreg, bus.commit_wdata, bus.commit_memaddr,
                     bus.commit_memdata};

  trace_fifo #(
    .W         (REC_W),
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (event_c),
    .pop_i       (bus.rd_ready),
    .data_i      (record_c),
    .valid_o     (bus.rd_valid),
    .head_o      (bus.rd_record),
    .occupancy_o (occupancy),
    .drop_o      (drop_c),
    .overwrite_o (overwrite_c)
  );

  // Run/drain/stop control with saturating counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      inst_count_q    <= '0;
      cycle_count_q   <= '0;
      dropped_count_q <= '0;
      overflow_q      <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (cycle_count_q != '1))
        cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (event_c && (inst_count_q != '1))
        inst_count_q <= inst_count_q + CNT_W'(1);
      if (drop_c && (dropped_count_q != '1))
        dropped_count_q <= dropped_count_q + CNT_W'(1);
      if (drop_c | overwrite_c)
        overflow_q <= 1'b1;

      case (state_q)
        ST_RUN: begin
          // A halt stops capture even if its own record was dropped.
          if (event_c && bus.commit_halt) begin
            state_q  <= ST_DRAIN;
            halted_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (occupancy == '0) state_q <= ST_STOPPED;
        end
        ST_STOPPED: state_q <= ST_STOPPED;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

  assign inst_count    = inst_count_q;
  assign cycle_count   = cycle_count_q;
  assign dropped_count = dropped_count_q;
  assign overflow      = overflow_q;
  assign halted        = halted_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable commit-trace recorder, parametrised successor to the simulation-only commit tracer. Sits beside the pipeline's writeback stage and samples one retire event per cycle (PC, instruction, register write, memory access, halt). Each event is classified, numbered and pushed into a circular buffer that a debug port drains over a valid/ready handshake. Also keeps cycle and instruction counters and a configurable overflow policy.

Parameters:
DATA_W, 16, width of PC, instruction, register data, memory address and memory data
REG_W, 3, register-select width
DEPTH, 16, buffer entries; power of two, >=2
CNT_W, 32, width of inst_count, cycle_count, dropped_count and of the record's inum field
WRAP_MODE, 0, 0 = drop new record when full; 1 = overwrite oldest when full

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  capture enable
commit_valid  in  1  an instruction retires this cycle (0 = bubble)
commit_pc  in  DATA_W  retiring PC
commit_inst  in  DATA_W  retiring instruction
commit_regwrite  in  1  register file write
commit_wreg  in  REG_W  written register
commit_wdata  in  DATA_W  written data
commit_memread  in  1  load
commit_memwrite  in  1  store
commit_memaddr  in  DATA_W  memory address
commit_memdata  in  DATA_W  store data
commit_halt  in  1  halt retires
rd_ready  in  1  consumer accepts head record
rd_valid  out  1  head record available
rd_record  out  REC_W  head record (layout in package)
occupancy  out  log2(DEPTH)+1  entries held
inst_count  out  CNT_W  records accepted (captured, dropped or overwriting)
cycle_count  out  CNT_W  cycles spent in RUN
dropped_count  out  CNT_W  records discarded (WRAP_MODE=0 only)
overflow  out  1  sticky: a drop or overwrite has occurred
halted  out  1  halt record accepted

Behaviour:
- Reset (sync, clk edge with rst=1): state RUN; all pointers, counters, flags 0; rd_valid=0, occupancy=0, rd_record don't-care. Memory contents are not cleared. Reset mid-operation discards everything.
- FSM: RUN -> DRAIN on accepted halt; DRAIN -> STOPPED when buffer becomes empty; STOPPED holds until reset. No capture in DRAIN/STOPPED. Reads are allowed in all states.
- Capture: event = state==RUN & enable & commit_valid. Bubbles and enable=0 are neither recorded nor counted. cycle_count increments every RUN cycle regardless of enable.
- Kind, priority order: halt=HALT; regwrite&memwrite=STU; regwrite&memread=LD; regwrite=REG; memwrite=ST; else=NOP (branch/nop).
- inum = inst_count value before the increment, so the first record has inum 0. inst_count increments once per event, including drops.
- Latency: the pushed record is visible at rd_record/rd_valid on the cycle after the event. No same-cycle bypass.
- Pop: rd_valid & rd_ready advances the head. rd_record is show-ahead, valid whenever rd_valid=1.
- Full and event, no pop:
  - WRAP_MODE=0: record discarded, dropped_count++, overflow=1.
  - WRAP_MODE=1: oldest entry overwritten, head advances, occupancy stays DEPTH, overflow=1.
- Full and event with pop in the same cycle: push succeeds in both modes, no drop, occupancy unchanged.
- Empty and event with pop: pop is ignored (rd_valid=0), push succeeds.
- Halt follows the same full rules. halted=1 and the state moves to DRAIN even if the halt record is dropped.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy uses an extra bit.
- Counters saturate at all-ones.

Decomposition:
- Package trace_pkg:
  - KIND_W=3 and kind encodings NOP=0, REG=1, LD=2, ST=3, STU=4, HALT=5.
  - State encodings RUN/DRAIN/STOPPED.
  - Record layout, MSB to LSB: inum, kind, pc, inst, wreg, wdata, addr, mdata.
  - REC_W = CNT_W + KIND_W + 5*DATA_W + REG_W.
- Sub-module trace_fifo: circular buffer with WRAP_MODE overwrite support. Parent holds the FSM, classification and counters.

Test Plan:
- Reset, 3 commits (REG r2=0x0005 at PC 0x0000; ST addr 0x0010 data 0x00AA; NOP), rd_ready=1 -> records inum 0,1,2, kinds REG/ST/NOP in order; each appears one cycle after its commit.
- DEPTH=4, WRAP_MODE=0, rd_ready=0, 6 commits -> occupancy=4, dropped_count=2, overflow=1, inst_count=6; drained inums 0..3.
- Same stimulus with WRAP_MODE=1 -> dropped_count=0, overflow=1; drained inums 2..5.
- Full buffer, commit with rd_ready=1 same cycle -> no drop, occupancy stays 4, overflow=0.
- Bubbles and enable=0 interleaved with 2 valid commits over 10 RUN cycles -> inst_count=2, cycle_count=10.
- Halt at inum 7 with 3 entries queued -> state DRAIN, later commits ignored; STOPPED after 3rd pop; last record kind HALT; rst pulse mid-drain -> occupancy=0, counters 0, state RUN.
